sub_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 16-bit subtractor (`Sub`, one-cycle registered `diff = a - b`) among N requesters in the ALU. Each cycle it grants at most one pending request and drives the winner's operands into the subtractor through an operand register. It returns the difference, a borrow flag and the requester ID two cycles later. The arbiter and `Sub` share `clk` and `rst`.

---
 rtl/sub_arbiter.sv | 91 +++++++++
 tb/tb_sub_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// Round-robin arbiter that feeds one shared registered subtractor and returns
// the tagged difference and borrow two cycles after each grant.
module sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       sub_a,
    output logic [W-1:0]       sub_b,
    input  logic [W-1:0]       sub_diff,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [W-1:0]       resp_diff,
    output logic               resp_borrow
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    logic [W-1:0]   win_a;
    logic [W-1:0]   win_b;

    // vld_pipe[1] tracks the operand register, vld_pipe[2] the subtractor output
    logic [2:1]     vld_pipe;
    logic [IDW-1:0] id1, id2;
    logic           bor1, bor2;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % N_REQ);
    endfunction

    // Search starts just past the last winner, so the previous winner is tried last
    always_comb begin
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = wrap(int'(last) + k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) req_ready[win] = 1'b1;
    end

    assign win_a = req_a[int'(win)*W +: W];
    assign win_b = req_b[int'(win)*W +: W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last  <= IDW'(N_REQ - 1);
            sub_a <= '0;
            sub_b <= '0;
            id1   <= '0;
            bor1  <= 1'b0;
        end else if (found) begin
            last  <= win;
            sub_a <= win_a;
            sub_b <= win_b;
            id1   <= win;
            bor1  <= (win_a < win_b);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id2      <= '0;
            bor2     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], found};
            id2      <= id1;
            bor2     <= bor1;
        end
    end

    assign resp_valid  = vld_pipe[2];
    assign resp_id     = id2;
    assign resp_borrow = bor2;
    assign resp_diff   = sub_diff;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter with a behavioural registered subtractor.
module tb_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [15:0] sub_a, sub_b, sub_diff;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [15:0] resp_diff;
    logic        resp_borrow;

    int total = 0;
    int bad   = 0;

    logic [3:0]  vmask [16];
    int          gexp  [16];
    logic [15:0] dexp  [4];
    logic        bexp  [4];

    always #5 clk = ~clk;

    // Stand-in for Sub: one-cycle registered difference, reset with the arbiter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sub_diff <= '0;
        else      sub_diff <= sub_a - sub_b;
    end

    sub_arbiter #(.N_REQ(4), .W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_diff(resp_diff), .resp_borrow(resp_borrow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Drive vmask[0..n-1], check each grant, then check each response two cycles later
    task automatic run(input int n);
        for (int c = 0; c < n + 2; c++) begin
            req_valid = (c < n) ? vmask[c] : 4'b0000;
            #1;
            if (c < n) chk("ready", {28'd0, req_ready}, 32'd1 << gexp[c]);
            if (c < 2) chk("idle", {31'd0, resp_valid}, 32'd0);
            else begin
                int g;
                g = gexp[c-2];
                chk("rvalid", {31'd0, resp_valid}, 32'd1);
                chk("rid", {30'd0, resp_id}, g);
                chk("rdiff", {16'd0, resp_diff}, {16'd0, dexp[g]});
                chk("rborrow", {31'd0, resp_borrow}, {31'd0, bexp[g]});
            end
            step();
        end
        #1;
        chk("drain", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        // 1: reset with everyone requesting
        rst = 1'b0;
        req_valid = 4'b1111;
        set_op(0, 16'h0010, 16'h0000);
        set_op(1, 16'h0020, 16'h0001);
        set_op(2, 16'h0005, 16'h0003);
        set_op(3, 16'h0040, 16'h0003);
        step(); step(); step();
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_sub_a", {16'd0, sub_a}, 32'd0);
        chk("rst_sub_b", {16'd0, sub_b}, 32'd0);
        chk("rst_diff", {16'd0, resp_diff}, 32'd0);
        chk("rst_id", {30'd0, resp_id}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_first", {28'd0, req_ready}, 32'h1);
        req_valid = 4'b0000;
        #1;
        chk("ready_none", {28'd0, req_ready}, 32'h0);
        step();

        // 2: single op on requester 2
        vmask[0] = 4'b0100; gexp[0] = 2;
        dexp[2] = 16'h0002; bexp[2] = 1'b0;
        run(1);

        // 3: wrap-around then zero, back to back on requester 0
        set_op(0, 16'h0003, 16'h0005);
        vmask[0] = 4'b0001; gexp[0] = 0;
        dexp[0] = 16'hFFFE; bexp[0] = 1'b1;
        run(1);
        set_op(0, 16'h0000, 16'h0000);
        dexp[0] = 16'h0000; bexp[0] = 1'b0;
        run(1);

        // 4: fairness after a fresh reset
        do_reset();
        set_op(0, 16'h0010, 16'h0000);
        set_op(1, 16'h0020, 16'h0001);
        set_op(2, 16'h0030, 16'h0002);
        set_op(3, 16'h0040, 16'h0003);
        dexp[0] = 16'h0010; dexp[1] = 16'h001F; dexp[2] = 16'h002E; dexp[3] = 16'h003D;
        for (int i = 0; i < 4; i++) bexp[i] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vmask[c] = 4'b1111;
            gexp[c]  = c % 4;
        end
        run(8);

        // 5: park pointer on 1, then 1 and 3 alternate, then 3 drops out
        vmask[0] = 4'b0010; gexp[0] = 1;
        run(1);
        set_op(1, 16'h0001, 16'h0002);
        set_op(3, 16'h8000, 16'h0001);
        dexp[1] = 16'hFFFF; bexp[1] = 1'b1;
        dexp[3] = 16'h7FFF; bexp[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vmask[c] = 4'b1010;
            gexp[c]  = (c % 2 == 0) ? 3 : 1;
        end
        for (int c = 4; c < 7; c++) begin
            vmask[c] = 4'b0010;
            gexp[c]  = 1;
        end
        run(7);

        // 6: reset right after two accepted grants
        do_reset();
        req_valid = 4'b0011;
        #1;
        chk("mid_g0", {28'd0, req_ready}, 32'h1);
        step();
        chk("mid_g1", {28'd0, req_ready}, 32'h2);
        step();
        rst = 1'b0;
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
            step();
        end
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mid_restart", {28'd0, req_ready}, 32'h1);
        chk("mid_sub_a", {16'd0, sub_a}, 32'd0);
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_after_valid", {31'd0, resp_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
